pc_sequencer: RTL and testbench

Next-PC sequencer for the single-cycle RISC datapath, sitting directly upstream of the 16-bit PC register (the `D_flip_flop_16_bit` instance holding PC). Each cycle it reads the current PC back from the register's Q and decides what to present on the register's D and LOAD inputs. It supports sequential fetch, PC-relative branch, absolute jump, pipeline-free stall and halt/resume. It also keeps a retired-instruction counter for bring-up.

---
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: chooses the next value for the 16-bit PC register.
// Sequential fetch, PC-relative branch, absolute jump, stall and
// halt/resume, plus a saturating counter of retired instructions.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] pc_q,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        branch_taken,
    input  logic [7:0]  branch_offset,
    output logic [15:0] pc_d,
    output logic        pc_load,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [15:0] retired_q;
    logic [15:0] retired_d;
    logic        retire;
    logic [15:0] seqPc;
    logic [15:0] branchPc;

    // Both relative targets wrap naturally in 16 bits, below zero and past FFFF.
    assign seqPc    = pc_q + 16'd1;
    assign branchPc = seqPc + {{8{branch_offset[7]}}, branch_offset};

    // Next-PC select and next state; clr overrides everything so the PC
    // register is loaded with the reset vector in the clr cycle itself.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_load = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    retire  = 1'b1;
                    state_d = ST_HALT;
                end else if (stall) begin
                    retire = 1'b0;
                end else if (jump) begin
                    pc_d    = jump_target;
                    pc_load = 1'b1;
                    retire  = 1'b1;
                end else if (branch_taken) begin
                    pc_d    = branchPc;
                    pc_load = 1'b1;
                    retire  = 1'b1;
                end else begin
                    pc_d    = seqPc;
                    pc_load = 1'b1;
                    retire  = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // BOOT, and the unused encoding recovers the same way.
                pc_d    = RESET_VECTOR;
                pc_load = 1'b1;
                state_d = ST_RUN;
            end
        endcase
        if (clr) begin
            pc_d    = RESET_VECTOR;
            pc_load = 1'b1;
            retire  = 1'b0;
            state_d = ST_BOOT;
        end
    end

    // Retired counter sticks at all-ones instead of wrapping.
    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // State and counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_BOOT;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven check of pc_sequencer with a behavioural
// model of the PC register closing the loop from pc_d/pc_load to pc_q.
module tb_pc_sequencer;

    typedef struct {
        string       name;
        logic        clr;
        logic        stall;
        logic        haltReq;
        logic        resume;
        logic        jump;
        logic [15:0] jumpTarget;
        logic        branchTaken;
        logic [7:0]  branchOffset;
        logic [15:0] expPcD;
        logic        expLoad;
        logic [15:0] expPc;
        logic [15:0] expRetired;
        logic        expHalted;
    } vector_t;

    logic        clock = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] pcReg = 16'h0000;
    logic        stall = 1'b0;
    logic        haltReq = 1'b0;
    logic        resume = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jumpTarget = 16'h0000;
    logic        branchTaken = 1'b0;
    logic [7:0]  branchOffset = 8'h00;
    logic [15:0] pcD;
    logic        pcLoad;
    logic        halted;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;
    vector_t vecs[$];

    pc_sequencer #(.RESET_VECTOR(16'h0010)) dut (
        .clk(clock),
        .clr(clr),
        .pc_q(pcReg),
        .stall(stall),
        .halt_req(haltReq),
        .resume(resume),
        .jump(jump),
        .jump_target(jumpTarget),
        .branch_taken(branchTaken),
        .branch_offset(branchOffset),
        .pc_d(pcD),
        .pc_load(pcLoad),
        .halted(halted),
        .retired(retired)
    );

    always #5 clock = ~clock;

    // Stand-in for the PC register that the sequencer drives.
    always @(posedge clock) begin
        if (pcLoad) begin
            pcReg <= pcD;
        end
    end

    function automatic vector_t mk(string name, logic c, logic s, logic h, logic r,
                                   logic j, logic [15:0] jt, logic b, logic [7:0] bo,
                                   logic [15:0] ePcD, logic eLoad, logic [15:0] ePc,
                                   logic [15:0] eRet, logic eHalt);
        vector_t v;
        v.name = name; v.clr = c; v.stall = s; v.haltReq = h; v.resume = r;
        v.jump = j; v.jumpTarget = jt; v.branchTaken = b; v.branchOffset = bo;
        v.expPcD = ePcD; v.expLoad = eLoad; v.expPc = ePc;
        v.expRetired = eRet; v.expHalted = eHalt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic drive(input vector_t v);
        clr = v.clr; stall = v.stall; haltReq = v.haltReq; resume = v.resume;
        jump = v.jump; jumpTarget = v.jumpTarget;
        branchTaken = v.branchTaken; branchOffset = v.branchOffset;
    endtask

    task automatic applyStimulus(input vector_t v);
        @(negedge clock);
        drive(v);
        #1;
        checkOutput({v.name, ".pc_d"}, pcD, v.expPcD);
        checkOutput({v.name, ".pc_load"}, {15'd0, pcLoad}, {15'd0, v.expLoad});
        @(posedge clock);
        #1;
        checkOutput({v.name, ".pc_q"}, pcReg, v.expPc);
        checkOutput({v.name, ".retired"}, retired, v.expRetired);
        checkOutput({v.name, ".halted"}, {15'd0, halted}, {15'd0, v.expHalted});
    endtask

    initial begin
        //              name        clr st hr rs jp target    br off    pcD      ld pc       ret      h
        vecs.push_back(mk("reset",   1, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0010, 1, 16'h0010, 16'h0000, 0));
        vecs.push_back(mk("boot",    0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0010, 1, 16'h0010, 16'h0000, 0));
        vecs.push_back(mk("seq1",    0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0011, 1, 16'h0011, 16'h0001, 0));
        vecs.push_back(mk("seq2",    0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0012, 1, 16'h0012, 16'h0002, 0));
        vecs.push_back(mk("stall1",  0, 1, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0012, 0, 16'h0012, 16'h0002, 0));
        vecs.push_back(mk("stall2",  0, 1, 0, 0, 1, 16'h7777, 0, 8'h00, 16'h0012, 0, 16'h0012, 16'h0002, 0));
        vecs.push_back(mk("seq3",    0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0013, 1, 16'h0013, 16'h0003, 0));
        vecs.push_back(mk("jmp20",   0, 0, 0, 0, 1, 16'h0020, 0, 8'h00, 16'h0020, 1, 16'h0020, 16'h0004, 0));
        vecs.push_back(mk("brneg",   0, 0, 0, 0, 0, 16'h0000, 1, 8'hFC, 16'h001D, 1, 16'h001D, 16'h0005, 0));
        vecs.push_back(mk("jmpbr",   0, 0, 0, 0, 1, 16'hABCD, 1, 8'h05, 16'hABCD, 1, 16'hABCD, 16'h0006, 0));
        vecs.push_back(mk("brpos",   0, 0, 0, 0, 0, 16'h0000, 1, 8'h7F, 16'hAC4D, 1, 16'hAC4D, 16'h0007, 0));
        vecs.push_back(mk("jmpFFFF", 0, 0, 0, 0, 1, 16'hFFFF, 0, 8'h00, 16'hFFFF, 1, 16'hFFFF, 16'h0008, 0));
        vecs.push_back(mk("wrap",    0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 1, 16'h0000, 16'h0009, 0));
        vecs.push_back(mk("brunder", 0, 0, 0, 0, 0, 16'h0000, 1, 8'hFE, 16'hFFFF, 1, 16'hFFFF, 16'h000A, 0));
        vecs.push_back(mk("jmp30",   0, 0, 0, 0, 1, 16'h0030, 0, 8'h00, 16'h0030, 1, 16'h0030, 16'h000B, 0));
        vecs.push_back(mk("halt",    0, 1, 1, 0, 1, 16'h1234, 0, 8'h00, 16'h0030, 0, 16'h0030, 16'h000C, 1));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk("held", 0, i[0], 0, 0, ~i[0], 16'h1234, 1, 8'h10,
                              16'h0030, 0, 16'h0030, 16'h000C, 1));
        end
        vecs.push_back(mk("resume",  0, 0, 0, 1, 1, 16'h1234, 0, 8'h00, 16'h0030, 0, 16'h0030, 16'h000C, 0));
        vecs.push_back(mk("refetch", 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0031, 1, 16'h0031, 16'h000D, 0));
        vecs.push_back(mk("rsmrun",  0, 0, 0, 1, 0, 16'h0000, 0, 8'h00, 16'h0032, 1, 16'h0032, 16'h000E, 0));
        vecs.push_back(mk("halt2",   0, 0, 1, 0, 0, 16'h0000, 0, 8'h00, 16'h0032, 0, 16'h0032, 16'h000F, 1));
        vecs.push_back(mk("clrhalt", 1, 0, 0, 1, 1, 16'h4444, 0, 8'h00, 16'h0010, 1, 16'h0010, 16'h0000, 0));
        vecs.push_back(mk("boot2",   0, 0, 0, 0, 1, 16'h4444, 0, 8'h00, 16'h0010, 1, 16'h0010, 16'h0000, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Saturation: 65534 plain fetches from 0010 leave retired at FFFE, pc at 000E.
        for (int n = 0; n < 65534; n++) begin
            @(negedge clock);
            drive(mk("run", 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        end
        @(posedge clock);
        #1;
        checkOutput("preSat.retired", retired, 16'hFFFE);
        checkOutput("preSat.pc_q", pcReg, 16'h000E);
        applyStimulus(mk("sat1", 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h000F, 1, 16'h000F, 16'hFFFF, 0));
        applyStimulus(mk("sat2", 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0010, 1, 16'h0010, 16'hFFFF, 0));
        applyStimulus(mk("sat3", 0, 0, 0, 0, 1, 16'h0100, 0, 8'h00, 16'h0100, 1, 16'h0100, 16'hFFFF, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
